game_status_led_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 33 +++
 rtl/tick_prescaler.sv | 37 +++
 rtl/game_status_led_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_game_status_led_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : game_pkg
// Purpose : Shared encodings for the Connect4 game: FSM state codes, game
//           status codes, and the state type of the status LED driver.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package game_pkg;

    // Game FSM state encodings
    localparam logic [1:0] GAME_INIT = 2'b00;
    localparam logic [1:0] P1_TURN   = 2'b01;
    localparam logic [1:0] P2_TURN   = 2'b10;
    localparam logic [1:0] END_GAME  = 2'b11;

    // Game status encodings
    localparam logic [1:0] STILL_PLAYING = 2'b00;
    localparam logic [1:0] P1_WINS       = 2'b01;
    localparam logic [1:0] P2_WINS       = 2'b10;
    localparam logic [1:0] TIE           = 2'b11;

    // Status LED driver states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TURN  = 3'd1,
        S_BLINK = 3'd2,
        S_CHASE = 3'd3,
        S_HOLD  = 3'd4
    } led_fsm_e;

endpackage : game_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : tick_prescaler
// Purpose : Free-running 0..DIV-1 counter with a single-cycle tick while the
//           count sits at DIV-1; wraps to 0 on that tick.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           clear - synchronous restart of the count at 0
//           tick  - high while the count equals DIV-1
// Revision: 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int DIV = 1,
    parameter int W   = $clog2(DIV + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    logic [W-1:0] r_cnt;

    assign tick = (r_cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/game_status_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : game_status_led_ctrl
// Purpose : Drives the board status LED row from the game FSM state and the
//           game status: steady turn indicator during play, winner blink or
//           tie chase at end of game, then a steady hold with anim_done.
// Ports   : clk         - rising-edge clock
//           rst_n       - asynchronous active-low reset
//           state       - game FSM state (GAME_INIT/P1_TURN/P2_TURN/END_GAME)
//           game_status - STILL_PLAYING/P1_WINS/P2_WINS/TIE
//           leds        - registered LED drive, NUM_LEDS wide
//           anim_done   - registered, high while the end-of-game hold shows
// Revision: 1.0 - initial release
// ============================================================================
module game_status_led_ctrl #(
    parameter int NUM_LEDS    = 8,
    parameter int BLINK_DIV   = 25_000_000,
    parameter int WIN_FLASHES = 3,
    parameter int CHASE_DIV   = 6_250_000,
    parameter int TIE_LAPS    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          state,
    input  logic [1:0]          game_status,
    output logic [NUM_LEDS-1:0] leds,
    output logic                anim_done
);
    import game_pkg::*;

    localparam int c_MAX_DIV   = (BLINK_DIV > CHASE_DIV) ? BLINK_DIV : CHASE_DIV;
    localparam int c_PRE_W     = $clog2(c_MAX_DIV + 1);
    localparam int c_POS_W     = $clog2(NUM_LEDS);
    localparam int c_HALF_W    = $clog2(2 * WIN_FLASHES + 2);
    localparam int c_LAP_W     = $clog2(TIE_LAPS + 2);
    // Guarded so a zero count never produces a negative constant
    localparam int c_LAST_HALF = (WIN_FLASHES > 0) ? 2 * WIN_FLASHES - 1 : 0;
    localparam int c_LAST_LAP  = (TIE_LAPS > 0) ? TIE_LAPS - 1 : 0;

    localparam logic [NUM_LEDS-1:0] c_ONE   = {{(NUM_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NUM_LEDS-1:0] c_ALL   = {NUM_LEDS{1'b1}};
    localparam logic [NUM_LEDS-1:0] c_TURN1 = c_ONE << (NUM_LEDS/2 - 1);
    localparam logic [NUM_LEDS-1:0] c_TURN2 = c_ONE << (NUM_LEDS/2);
    localparam logic [NUM_LEDS-1:0] c_WIN1  = c_ONE;
    localparam logic [NUM_LEDS-1:0] c_WIN2  = c_ONE << (NUM_LEDS - 1);

    led_fsm_e              r_fsm,    w_fsm_nxt;
    logic [NUM_LEDS-1:0]   r_leds,   w_leds_nxt;
    logic                  r_done,   w_done_nxt;
    logic [c_POS_W-1:0]    r_pos,    w_pos_nxt;
    logic [c_HALF_W-1:0]   r_halves, w_halves_nxt;
    logic [c_LAP_W-1:0]    r_laps,   w_laps_nxt;
    logic [3:0]            r_prev;
    logic                  r_valid;

    logic                  w_restart;
    logic                  w_blink_tick;
    logic                  w_chase_tick;
    logic [NUM_LEDS-1:0]   w_tgt;
    logic [c_POS_W-1:0]    w_pos_inc;
    logic [c_HALF_W-1:0]   w_halves_inc;

    // The first sample after reset always counts as a change, so inputs held
    // across a reset restart their pattern from t=1.
    assign w_restart    = !r_valid || ({state, game_status} != r_prev);
    // Outside a restart the live inputs equal the stored sample, so the
    // winner target can be decoded straight from game_status.
    assign w_tgt        = (game_status == P2_WINS) ? c_WIN2 : c_WIN1;
    assign w_pos_inc    = r_pos + 1'b1;
    assign w_halves_inc = r_halves + 1'b1;

    tick_prescaler #(.DIV(BLINK_DIV), .W(c_PRE_W)) u_blink_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_restart),
        .tick  (w_blink_tick)
    );

    tick_prescaler #(.DIV(CHASE_DIV), .W(c_PRE_W)) u_chase_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_restart),
        .tick  (w_chase_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm    <= S_IDLE;
            r_leds   <= '0;
            r_done   <= 1'b0;
            r_pos    <= '0;
            r_halves <= '0;
            r_laps   <= '0;
            r_prev   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_fsm    <= w_fsm_nxt;
            r_leds   <= w_leds_nxt;
            r_done   <= w_done_nxt;
            r_pos    <= w_pos_nxt;
            r_halves <= w_halves_nxt;
            r_laps   <= w_laps_nxt;
            r_prev   <= {state, game_status};
            r_valid  <= 1'b1;
        end
    end

    always_comb begin
        w_fsm_nxt    = r_fsm;
        w_leds_nxt   = r_leds;
        w_done_nxt   = r_done;
        w_pos_nxt    = r_pos;
        w_halves_nxt = r_halves;
        w_laps_nxt   = r_laps;

        if (w_restart) begin
            w_pos_nxt    = '0;
            w_halves_nxt = '0;
            w_laps_nxt   = '0;
            w_done_nxt   = 1'b0;
            case (state)
                P1_TURN: begin
                    w_fsm_nxt  = S_TURN;
                    w_leds_nxt = c_TURN1;
                end
                P2_TURN: begin
                    w_fsm_nxt  = S_TURN;
                    w_leds_nxt = c_TURN2;
                end
                END_GAME: begin
                    if (game_status == P1_WINS || game_status == P2_WINS) begin
                        w_leds_nxt = w_tgt;
                        if (WIN_FLASHES == 0) begin
                            w_fsm_nxt  = S_HOLD;
                            w_done_nxt = 1'b1;
                        end else begin
                            w_fsm_nxt  = S_BLINK;
                        end
                    end else if (TIE_LAPS == 0) begin
                        // STILL_PLAYING at END_GAME falls in with TIE
                        w_fsm_nxt  = S_HOLD;
                        w_leds_nxt = c_ALL;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_fsm_nxt  = S_CHASE;
                        w_leds_nxt = c_ONE;
                    end
                end
                default: begin
                    w_fsm_nxt  = S_IDLE;
                    w_leds_nxt = '0;
                end
            endcase
        end else begin
            case (r_fsm)
                S_BLINK: begin
                    // Each tick ends one half-period; even count = on phase
                    if (w_blink_tick) begin
                        if (r_halves == c_HALF_W'(c_LAST_HALF)) begin
                            w_fsm_nxt  = S_HOLD;
                            w_leds_nxt = w_tgt;
                            w_done_nxt = 1'b1;
                        end else begin
                            w_halves_nxt = w_halves_inc;
                            w_leds_nxt   = w_halves_inc[0] ? '0 : w_tgt;
                        end
                    end
                end
                S_CHASE: begin
                    if (w_chase_tick) begin
                        if (r_pos == c_POS_W'(NUM_LEDS - 1)) begin
                            if (r_laps == c_LAP_W'(c_LAST_LAP)) begin
                                w_fsm_nxt  = S_HOLD;
                                w_leds_nxt = c_ALL;
                                w_done_nxt = 1'b1;
                            end else begin
                                w_laps_nxt = r_laps + 1'b1;
                                w_pos_nxt  = '0;
                                w_leds_nxt = c_ONE;
                            end
                        end else begin
                            w_pos_nxt  = w_pos_inc;
                            w_leds_nxt = c_ONE << w_pos_inc;
                        end
                    end
                end
                default: begin
                    // IDLE, TURN and HOLD are static until the inputs change
                end
            endcase
        end
    end

    assign leds      = r_leds;
    assign anim_done = r_done;

endmodule : game_status_led_ctrl
`default_nettype wire

// File: tb/tb_game_status_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_game_status_led_ctrl
// Purpose : Self-checking bench for game_status_led_ctrl. Three instances with
//           different parameter sets share the inputs; a time-based model
//           (pattern as a function of cycles since the last input change)
//           predicts every output each cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_game_status_led_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] state;
    logic [1:0] game_status;
    logic [7:0] leds_a;
    logic [3:0] leds_b;
    logic [1:0] leds_c;
    logic       done_a, done_b, done_c;

    int n_tests = 0;
    int n_fail  = 0;

    // A: the reference configuration
    game_status_led_ctrl #(.NUM_LEDS(8), .BLINK_DIV(4), .WIN_FLASHES(2),
                           .CHASE_DIV(2), .TIE_LAPS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .state(state), .game_status(game_status),
        .leds(leds_a), .anim_done(done_a));

    // B: no win animation, two chase laps
    game_status_led_ctrl #(.NUM_LEDS(4), .BLINK_DIV(1), .WIN_FLASHES(0),
                           .CHASE_DIV(3), .TIE_LAPS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .state(state), .game_status(game_status),
        .leds(leds_b), .anim_done(done_b));

    // C: minimum row, divide-by-one blink, no chase
    game_status_led_ctrl #(.NUM_LEDS(2), .BLINK_DIV(1), .WIN_FLASHES(3),
                           .CHASE_DIV(1), .TIE_LAPS(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .state(state), .game_status(game_status),
        .leds(leds_c), .anim_done(done_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got done/leds=%h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {anim_done, leds} for t cycles after the latest input change.
    function automatic logic [8:0] model(int n, int bdiv, int wf, int cdiv, int laps,
                                         logic [1:0] st, logic [1:0] gs, int t);
        int half;
        int step;
        logic [7:0] tgt;
        case (st)
            2'b00: return 9'h000;
            2'b01: return {1'b0, 8'(1 << (n/2 - 1))};
            2'b10: return {1'b0, 8'(1 << (n/2))};
            default: begin
                if (gs == 2'b01 || gs == 2'b10) begin
                    tgt  = (gs == 2'b01) ? 8'h01 : 8'(1 << (n - 1));
                    half = (t - 1) / bdiv;
                    if (half >= 2 * wf) return {1'b1, tgt};
                    return {1'b0, (half % 2 == 0) ? tgt : 8'h00};
                end
                step = (t - 1) / cdiv;
                if (step >= n * laps) return {1'b1, 8'((1 << n) - 1)};
                return {1'b0, 8'(1 << (step % n))};
            end
        endcase
    endfunction

    // Model bookkeeping and per-cycle comparison
    logic       m_valid = 1'b0;
    logic [3:0] m_prev  = 4'h0;
    int         m_t     = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_valid = 1'b0;
            end else if (!m_valid || {state, game_status} != m_prev) begin
                m_valid = 1'b1;
                m_prev  = {state, game_status};
                m_t     = 1;
            end else if (m_t < 1000000) begin
                m_t++;
            end
            #1;
            if (!rst_n || !m_valid) begin
                chk("rst_a", {done_a, leds_a}, 9'h000);
            end else begin
                chk("model_a", {done_a, leds_a},
                    model(8, 4, 2, 2, 1, m_prev[3:2], m_prev[1:0], m_t));
                chk("model_b", {done_b, 4'h0, leds_b},
                    model(4, 1, 0, 3, 2, m_prev[3:2], m_prev[1:0], m_t));
                chk("model_c", {done_c, 6'h00, leds_c},
                    model(2, 1, 3, 1, 0, m_prev[3:2], m_prev[1:0], m_t));
            end
        end
    end

    task automatic set_in(input logic [1:0] st, input logic [1:0] gs);
        @(negedge clk);
        state       = st;
        game_status = gs;
    endtask

    initial begin
        logic [1:0] rs, rg;
        int         len;

        rst_n       = 1'b0;
        state       = 2'b00;
        game_status = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_state", {done_a, leds_a}, 9'h000);
        rst_n = 1'b1;

        // Turn indicators
        set_in(2'b01, 2'b00); @(negedge clk); chk("p1_turn", {done_a, leds_a}, 9'h008);
        state = 2'b10;        @(negedge clk); chk("p2_turn", {done_a, leds_a}, 9'h010);
        state = 2'b00;        @(negedge clk); chk("init",    {done_a, leds_a}, 9'h000);

        // P1 win blink
        state = 2'b11; game_status = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1)  chk("blink_t1",  {done_a, leds_a}, 9'h001);
            if (k == 5)  chk("blink_t5",  {done_a, leds_a}, 9'h000);
            if (k == 9)  chk("blink_t9",  {done_a, leds_a}, 9'h001);
            if (k == 16) chk("blink_t16", {done_a, leds_a}, 9'h000);
            if (k == 17) chk("blink_t17", {done_a, leds_a}, 9'h101);
            if (k == 20) chk("blink_hold", {done_a, leds_a}, 9'h101);
        end

        // Tie chase
        game_status = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2)  chk("chase_t2",  {done_a, leds_a}, 9'h001);
            if (k == 3)  chk("chase_t3",  {done_a, leds_a}, 9'h002);
            if (k == 16) chk("chase_t16", {done_a, leds_a}, 9'h080);
            if (k == 17) chk("chase_t17", {done_a, leds_a}, 9'h1FF);
        end

        // P2 blink, asynchronous reset mid-animation
        game_status = 2'b10;
        repeat (6) @(negedge clk);
        chk("p2_blink_t6", {done_a, leds_a}, 9'h000);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {done_a, leds_a}, 9'h000);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); chk("rst_restart_t1", {done_a, leds_a}, 9'h180 & 9'h080);
        repeat (3) @(negedge clk); chk("rst_restart_t4", {done_a, leds_a}, 9'h080);
        @(negedge clk); chk("rst_restart_t5", {done_a, leds_a}, 9'h000);

        // Status switch mid-blink restarts as a chase
        set_in(2'b11, 2'b01);
        repeat (6) @(negedge clk);
        game_status = 2'b11;
        @(negedge clk); chk("switch_chase", {done_a, leds_a}, 9'h001);

        // STILL_PLAYING at END_GAME is a tie
        set_in(2'b11, 2'b00);
        repeat (16) @(negedge clk); chk("sp_t16", {done_a, leds_a}, 9'h080);
        @(negedge clk);             chk("sp_t17", {done_a, leds_a}, 9'h1FF);

        // Zero flash count: immediate hold
        set_in(2'b01, 2'b00);
        set_in(2'b11, 2'b01);
        @(negedge clk); chk("wf0_t1", {done_b, 4'h0, leds_b}, 9'h101);

        // Randomised sequences
        for (int i = 0; i < 300; i++) begin
            rs = 2'($urandom_range(0, 3));
            rg = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) rs = 2'b11;
            set_in(rs, rg);
            len = $urandom_range(1, 45);
            repeat (len) @(negedge clk);
            if ($urandom_range(0, 14) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rand_async_rst", {done_a, leds_a}, 9'h000);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_game_status_led_ctrl
`default_nettype wire
